adder_resp_checker: RTL and testbench

//  Self-checking response analyser for the registered 32-bit adder.
//  - Receives the same A/B/Cin stream that drives the adder.
//  - Computes the golden {Cout,S} and delays it by the adder latency.
//  - Compares the golden value with the adder's registered outputs.
//  - Counts vectors and mismatches, and captures the first failure.
//  - Sits beside the adder on-chip (BIST) or in the bench as the checking end.

---
 rtl/adder_resp_checker.sv | 136 +++++++++++++
 tb/tb_adder_resp_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_resp_checker.sv
// rtl/adder_resp_checker.sv - response checker for the registered adder: golden pipeline, compare, counters, first-failure capture
module adder_resp_checker #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             vec_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [WIDTH-1:0] dut_S,
    input  logic             dut_Cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH:0]   first_err_exp,
    output logic [WIDTH:0]   first_err_got
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = 1;
    localparam logic [3:0]       DRAIN_LAST = 4'(LATENCY - 1);

    state_t             state;
    logic [LATENCY-1:0] pipe_v;
    logic [WIDTH:0]     pipe_gold [LATENCY];
    logic [CNT_W-1:0]   pipe_idx  [LATENCY];
    logic [CNT_W-1:0]   in_idx;
    logic [3:0]         drain_cnt;

    logic [WIDTH:0]     golden_in;
    logic [WIDTH:0]     observed;
    logic               cmp_valid;
    logic               cmp_mis;

    assign golden_in = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    assign observed  = {dut_Cout, dut_S};
    assign cmp_valid = pipe_v[LATENCY-1];
    assign cmp_mis   = cmp_valid && (observed != pipe_gold[LATENCY-1]);

    // Payload stages carry no reset: they are only ever read when the matching valid bit is set.
    always_ff @(posedge clk) begin
        pipe_gold[0] <= golden_in;
        pipe_idx[0]  <= in_idx;
        for (int k = 1; k < LATENCY; k++) begin
            pipe_gold[k] <= pipe_gold[k-1];
            pipe_idx[k]  <= pipe_idx[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
            pipe_v        <= '0;
            in_idx        <= '0;
            drain_cnt     <= '0;
        end else begin
            done <= 1'b0;

            pipe_v[0] <= (state == RUN) && vec_valid;
            for (int k = 1; k < LATENCY; k++) begin
                pipe_v[k] <= pipe_v[k-1];
            end
            if ((state == RUN) && vec_valid) begin
                in_idx <= in_idx + CNT_ONE;
            end

            if (cmp_valid && (vec_cnt != CNT_MAX)) begin
                vec_cnt <= vec_cnt + CNT_ONE;
            end
            if (cmp_mis) begin
                if (err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
                if (err_cnt == '0) begin
                    first_err_idx <= pipe_idx[LATENCY-1];
                    first_err_exp <= pipe_gold[LATENCY-1];
                    first_err_got <= observed;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        pass          <= 1'b0;
                        vec_cnt       <= '0;
                        err_cnt       <= '0;
                        first_err_idx <= '0;
                        first_err_exp <= '0;
                        first_err_got <= '0;
                        pipe_v        <= '0;
                        in_idx        <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    // The last vector reaches the compare stage in the final drain cycle.
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0) && !cmp_mis;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_resp_checker.sv
// tb/tb_adder_resp_checker.sv - directed and random checks of adder_resp_checker at two latency/width settings
module tb_adder_resp_checker;

    localparam int W  = 32;
    localparam int L1 = 2;
    localparam int C1 = 16;
    localparam int L2 = 3;
    localparam int C2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         vec_valid = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         flip = 1'b0;

    logic [W:0] adder_pipe [0:7];

    always @(posedge clk) begin
        adder_pipe[0] <= vec_valid ? (({1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin}) ^ {{W{1'b0}}, flip})
                                   : {1'($urandom), 32'($urandom)};
        for (int k = 1; k < 8; k++) adder_pipe[k] <= adder_pipe[k-1];
    end

    logic          busy1, done1, pass1;
    logic [C1-1:0] vec_cnt1, err_cnt1, fidx1;
    logic [W:0]    fexp1, fgot1;
    logic          busy2, done2, pass2;
    logic [C2-1:0] vec_cnt2, err_cnt2, fidx2;
    logic [W:0]    fexp2, fgot2;

    adder_resp_checker #(.WIDTH(W), .LATENCY(L1), .CNT_W(C1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .vec_valid(vec_valid),
        .A(A), .B(B), .Cin(Cin),
        .dut_S(adder_pipe[L1-1][W-1:0]), .dut_Cout(adder_pipe[L1-1][W]),
        .busy(busy1), .done(done1), .pass(pass1),
        .vec_cnt(vec_cnt1), .err_cnt(err_cnt1), .first_err_idx(fidx1),
        .first_err_exp(fexp1), .first_err_got(fgot1)
    );

    adder_resp_checker #(.WIDTH(W), .LATENCY(L2), .CNT_W(C2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .vec_valid(vec_valid),
        .A(A), .B(B), .Cin(Cin),
        .dut_S(adder_pipe[L2-1][W-1:0]), .dut_Cout(adder_pipe[L2-1][W]),
        .busy(busy2), .done(done2), .pass(pass2),
        .vec_cnt(vec_cnt2), .err_cnt(err_cnt2), .first_err_idx(fidx2),
        .first_err_exp(fexp2), .first_err_got(fgot2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of one run: everything derives from the list of vectors sent.
    int         n_vec;
    int         n_err;
    bit         have_err;
    int         first_idx;
    logic [W:0] first_exp;
    logic [W:0] first_got;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        n_vec = 0; n_err = 0; have_err = 0; first_idx = 0;
        first_exp = '0; first_got = '0;
    endtask

    task automatic model_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic f);
        logic [W:0] g;
        g = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        if (f) begin
            if (!have_err) begin
                have_err = 1; first_idx = n_vec; first_exp = g; first_got = g ^ 33'd1;
            end
            n_err++;
        end
        n_vec++;
    endtask

    task automatic drive_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic f);
        A = a; B = b; Cin = c; flip = f; vec_valid = 1'b1;
        model_add(a, b, c, f);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic f);
        drive_vec(a, b, c, f);
        step();
        vec_valid = 1'b0; flip = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            A = $urandom; B = $urandom; Cin = 1'($urandom); flip = 1'($urandom);
            vec_valid = 1'b0;
            step();
        end
        flip = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        model_clear();
    endtask

    task automatic end_run(input string tag, input bit with_vec,
                           input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic f);
        int k1, k2, d1n, d2n;
        k1 = 0; k2 = 0; d1n = 0; d2n = 0;
        if (with_vec) drive_vec(a, b, c, f);
        stop = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            stop = 1'b0; vec_valid = 1'b0; flip = 1'b0;
            if (done1 === 1'b1) begin d1n++; if (k1 == 0) k1 = k; end
            if (done2 === 1'b1) begin d2n++; if (k2 == 0) k2 = k; end
        end
        chk({tag, ".done_lat1"}, k1, L1 + 1);
        chk({tag, ".done_lat2"}, k2, L2 + 1);
        chk({tag, ".done_cnt1"}, d1n, 1);
        chk({tag, ".done_cnt2"}, d2n, 1);
        chk({tag, ".busy1"}, busy1, 0);
        chk({tag, ".vec1"}, vec_cnt1, sat(n_vec, C1));
        chk({tag, ".err1"}, err_cnt1, sat(n_err, C1));
        chk({tag, ".pass1"}, pass1, (n_err == 0));
        chk({tag, ".fidx1"}, fidx1, have_err ? first_idx : 0);
        chk({tag, ".fexp1"}, fexp1, have_err ? first_exp : 0);
        chk({tag, ".fgot1"}, fgot1, have_err ? first_got : 0);
        chk({tag, ".vec2"}, vec_cnt2, sat(n_vec, C2));
        chk({tag, ".err2"}, err_cnt2, sat(n_err, C2));
        chk({tag, ".pass2"}, pass2, (n_err == 0));
        chk({tag, ".fidx2"}, fidx2, have_err ? (first_idx % (1 << C2)) : 0);
        chk({tag, ".fexp2"}, fexp2, have_err ? first_exp : 0);
    endtask

    task automatic send_fixed(input int flip_idx);
        send($urandom, $urandom, 1'($urandom), flip_idx == 0);
        send(32'h000000FF, 32'h00000001, 1'b0, flip_idx == 1);
        send(32'h12340000, 32'h43210000, 1'b1, flip_idx == 2);
        send(32'hFFFFFFFF, 32'h0001FFFF, 1'b1, flip_idx == 3);
        send(32'hABCD0000, 32'h12340001, 1'b0, flip_idx == 4);
    endtask

    initial begin
        int dn;
        model_clear();

        // Reset state
        rst = 1'b0;
        step(); step();
        chk("rst.busy", {busy1, busy2}, 0);
        chk("rst.done", {done1, done2}, 0);
        chk("rst.pass", {pass1, pass2}, 0);
        chk("rst.cnt1", {vec_cnt1, err_cnt1, fidx1}, 0);
        chk("rst.cap1", {fexp1, fgot1}, 0);
        rst = 1'b1;
        step();

        // Clean run of five vectors, including the carry-out and carry-in cases
        start_run();
        chk("run.busy", {busy1, busy2}, 2'b11);
        chk("run.pass", {pass1, pass2}, 0);
        send_fixed(-1);
        gap(2);
        end_run("clean", 0, 0, 0, 0, 0);

        // Single bit-0 fault on vector index 2
        start_run();
        send_fixed(2);
        end_run("fault2", 0, 0, 0, 0, 0);
        chk("fault2.exp_const", fexp1, 33'h0_55550001);
        chk("fault2.got_const", fgot1, 33'h0_55550000);
        chk("fault2.idx_const", fidx1, 2);

        // Random vectors with gaps and sparse faults, last vector shares the stop cycle
        start_run();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(2, 0) == 0) gap($urandom_range(3, 1));
            send($urandom, $urandom, 1'($urandom), $urandom_range(7, 0) == 0);
        end
        gap(1);
        end_run("rand", 1, $urandom, $urandom, 1'($urandom), 1'b0);

        // Reset while draining discards the run without a done pulse
        start_run();
        send($urandom, $urandom, 1'b0, 1'b1);
        send($urandom, $urandom, 1'b1, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("drain.busy", busy1, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("drain_rst.busy", {busy1, busy2}, 0);
        chk("drain_rst.cnt1", {vec_cnt1, err_cnt1, fidx1, pass1, done1}, 0);
        chk("drain_rst.cap1", {fexp1, fgot1}, 0);
        chk("drain_rst.cnt2", {vec_cnt2, err_cnt2, fidx2, pass2, done2}, 0);
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done1 === 1'b1 || done2 === 1'b1 || busy1 === 1'b1) dn++;
        end
        chk("drain_rst.quiet", dn, 0);

        // Start pulsed mid-run is ignored
        start_run();
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'($urandom), i == 1);
        start = 1'b1;
        gap(1);
        start = 1'b0;
        for (int i = 0; i < 2; i++) send($urandom, $urandom, 1'($urandom), 1'b0);
        end_run("start_in_run", 0, 0, 0, 0, 0);

        // Counter saturation on the narrow instance
        start_run();
        for (int i = 0; i < 20; i++) send($urandom, $urandom, 1'($urandom), 1'b1);
        end_run("sat", 0, 0, 0, 0, 0);
        chk("sat.err2_const", err_cnt2, 15);
        chk("sat.vec2_const", vec_cnt2, 15);
        chk("sat.err1_const", err_cnt1, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
